inst_fetch_stage: RTL and testbench

INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

---
 rtl/inst_fetch_stage.sv | 134 +++++++++++++
 tb/tb_inst_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a 2-entry {word, pc} buffer and a
// registered IF/ID output. Flush redirects fetch and drains any request already in flight.
module inst_fetch_stage #(
  parameter int unsigned      ISIZE    = 32,
  parameter int unsigned      PSIZE    = 32,
  parameter logic [PSIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [PSIZE-1:0] flush_pc,
  output logic             imem_req,
  output logic [PSIZE-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [ISIZE-1:0] imem_rdata,
  output logic [ISIZE-1:0] inst,
  output logic             inst_valid,
  output logic [PSIZE-1:0] inst_pc
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_req;
  logic [PSIZE-1:0] r_addr;
  logic [PSIZE-1:0] r_fetch_pc;
  logic [PSIZE-1:0] w_fetch_pc_next;

  logic [ISIZE-1:0] r_fifo_word [2];
  logic [PSIZE-1:0] r_fifo_pc   [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic [1:0]       w_count_next;
  logic             w_push;
  logic             w_pop;

  logic [ISIZE-1:0] r_inst;
  logic             r_inst_valid;
  logic [PSIZE-1:0] r_inst_pc;

  always_comb begin
    w_push          = (r_state == StWait) && imem_ack && !flush;
    w_pop           = !flush && !stall && (r_count != 2'd0);
    w_count_next    = flush ? 2'd0 : (r_count + {1'b0, w_push} - {1'b0, w_pop});
    w_fetch_pc_next = r_fetch_pc;
    if (flush) begin
      w_fetch_pc_next = flush_pc;
    end else if (w_push) begin
      w_fetch_pc_next = r_fetch_pc + PSIZE'(4);
    end

    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!flush && (w_count_next < 2'd2)) w_state_next = StWait;
      end
      StWait: begin
        // A flushed request still owes us an ack unless it arrives this very cycle
        if (flush) begin
          w_state_next = imem_ack ? StIdle : StDrop;
        end else if (imem_ack) begin
          w_state_next = (w_count_next < 2'd2) ? StWait : StIdle;
        end
      end
      StDrop: begin
        if (imem_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_req      <= (w_state_next != StIdle);
      r_fetch_pc <= w_fetch_pc_next;
      // While draining, the bus keeps the old address even though fetch_pc has moved on
      if (w_state_next != StDrop) r_addr <= w_fetch_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_word[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= 2'd0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
    end else begin
      r_count <= w_count_next;
      if (flush) begin
        r_wptr       <= 1'b0;
        r_rptr       <= 1'b0;
        r_inst       <= '0;
        r_inst_valid <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo_word[r_wptr] <= imem_rdata;
          r_fifo_pc[r_wptr]   <= r_fetch_pc;
          r_wptr              <= ~r_wptr;
        end
        if (w_pop) begin
          r_inst       <= r_fifo_word[r_rptr];
          r_inst_pc    <= r_fifo_pc[r_rptr];
          r_inst_valid <= 1'b1;
          r_rptr       <= ~r_rptr;
        end else if (!stall) begin
          r_inst       <= '0;
          r_inst_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: directed scenarios then randomized stall/flush/latency, checked
// against an in-order fetch-stream model and a bus-stability monitor.
module tb_inst_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;

  logic        man_mode = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  int          lat_max = 0;
  int          lat_left = 0;

  int          n_vec = 0;
  int          n_err = 0;
  int          delivered = 0;
  logic [31:0] exp_pc = RstPc;

  inst_fetch_stage #(.ISIZE(32), .PSIZE(32), .RESET_PC(RstPc)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  assign imem_ack   = man_mode ? man_ack : auto_ack;
  assign imem_rdata = man_mode ? man_rdata : auto_rdata;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!inst_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, inst_valid, 1);
  endtask

  // Memory model: random latency per request, data is a fixed function of the address
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      auto_ack = 1'b0;
    end else if (lat_left == 0) begin
      auto_ack   = 1'b1;
      auto_rdata = memfn(imem_addr);
      lat_left   = int'($urandom_range(0, lat_max));
    end else begin
      auto_ack = 1'b0;
      lat_left--;
    end
  end

  // Reference model: every fresh instruction is the next address of the current fetch stream
  logic        s_stall, s_flush, s_rst, s_req, s_ack;
  logic [31:0] s_fpc, s_addr;
  logic        pr_req = 1'b0, pr_ack = 1'b0;
  logic [31:0] pr_addr = '0;
  logic [31:0] h_inst = '0, h_pc = '0;
  logic        h_valid = 1'b0;

  always begin
    @(posedge clk);
    s_stall = stall;
    s_flush = flush;
    s_fpc   = flush_pc;
    s_rst   = rst;
    s_req   = imem_req;
    s_ack   = imem_ack;
    s_addr  = imem_addr;
    if (s_rst && pr_req && !pr_ack && s_req) check("addr_stable", s_addr, pr_addr);
    pr_req  = s_rst && s_req;
    pr_ack  = s_ack;
    pr_addr = s_addr;
    #1;
    if (!rst || !s_rst) begin
      exp_pc = RstPc;
    end else if (s_flush) begin
      check("m_flush_valid", inst_valid, 0);
      exp_pc = s_fpc;
    end else if (s_stall) begin
      check("m_hold_valid", inst_valid, h_valid);
      check("m_hold_inst", inst, h_inst);
      check("m_hold_pc", inst_pc, h_pc);
    end else if (inst_valid) begin
      check("m_seq_pc", inst_pc, exp_pc);
      check("m_seq_inst", inst, memfn(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else begin
      check("m_nop_inst", inst, 0);
    end
    h_inst  = inst;
    h_valid = inst_valid;
    h_pc    = inst_pc;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    int          d0;

    // Reset state
    repeat (3) tick();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RstPc);
    check("rst_inst", inst, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", inst_pc, 0);

    // Zero-wait memory, no stall: first valid at edge 3, then 1 per cycle
    rst = 1'b1;
    tick();
    check("e1_req", imem_req, 1);
    check("e1_addr", imem_addr, 32'h0);
    check("e1_valid", inst_valid, 0);
    tick();
    check("e2_valid", inst_valid, 0);
    check("e2_addr", imem_addr, 32'h4);
    tick();
    check("e3_valid", inst_valid, 1);
    check("e3_pc", inst_pc, 32'h0);
    tick();
    check("e4_pc", inst_pc, 32'h4);
    tick();
    check("e5_pc", inst_pc, 32'h8);

    // Stall for 5 cycles
    held  = inst_pc;
    stall = 1'b1;
    repeat (5) tick();
    check("st_hold_pc", inst_pc, held);
    check("st_req_low", imem_req, 0);
    stall = 1'b0;
    tick();
    check("st_valid", inst_valid, 1);
    check("st_next_pc", inst_pc, held + 32'd4);

    // Flush while waiting, ack arrives later and is dropped
    man_mode = 1'b1;
    man_ack  = 1'b0;
    repeat (2) tick();
    check("fl_pre_req", imem_req, 1);
    held     = imem_addr;
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check("fl_valid", inst_valid, 0);
    check("fl_drop_req", imem_req, 1);
    check("fl_drop_addr", imem_addr, held);
    tick();
    check("fl_drop_addr2", imem_addr, held);
    man_ack   = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    tick();
    man_ack = 1'b0;
    check("fl_idle_req", imem_req, 0);
    man_mode = 1'b0;
    tick();
    check("fl_req", imem_req, 1);
    check("fl_addr", imem_addr, 32'h100);
    wait_valid("fl_wait");
    check("fl_first_pc", inst_pc, 32'h100);

    // Flush and ack in the same cycle
    repeat (3) tick();
    flush    = 1'b1;
    flush_pc = 32'h200;
    tick();
    flush = 1'b0;
    check("fa_valid", inst_valid, 0);
    check("fa_req_low", imem_req, 0);
    tick();
    check("fa_req", imem_req, 1);
    check("fa_addr", imem_addr, 32'h200);
    wait_valid("fa_wait");
    check("fa_first_pc", inst_pc, 32'h200);

    // Flush together with stall while the buffer is full
    stall = 1'b1;
    repeat (3) tick();
    check("fs_full_req", imem_req, 0);
    flush    = 1'b1;
    flush_pc = 32'h300;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    check("fs_valid", inst_valid, 0);
    tick();
    check("fs_req", imem_req, 1);
    check("fs_addr", imem_addr, 32'h300);
    wait_valid("fs_wait");
    check("fs_first_pc", inst_pc, 32'h300);

    // Asynchronous reset between edges while a request is outstanding
    repeat (3) tick();
    check("rw_pre_valid", inst_valid, 1);
    man_mode = 1'b1;
    man_ack  = 1'b0;
    tick();
    check("rw_pre_req", imem_req, 1);
    #3;
    rst = 1'b0;
    #1;
    check("rw_req", imem_req, 0);
    check("rw_valid", inst_valid, 0);
    check("rw_inst", inst, 0);
    check("rw_addr", imem_addr, RstPc);
    tick();
    rst      = 1'b1;
    man_mode = 1'b0;
    wait_valid("rw_wait");
    check("rw_first_pc", inst_pc, RstPc);

    // Randomized stall, flush and memory latency
    d0      = delivered;
    lat_max = 2;
    repeat (1500) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      flush_pc = 32'($urandom_range(0, 1023)) << 2;
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    repeat (5) tick();
    check("rnd_progress", ((delivered - d0) > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
